// File: rtl/spi_reg_peripheral_if.sv
// SPI pin bundle between an external controller (master) and the register peripheral (slave).
// All three pins are asynchronous to the peripheral's system clock.
interface spi_reg_peripheral_if;
    logic sclk;
    logic copi;
    logic ncs;

    modport master (output sclk, output copi, output ncs);
    modport slave  (input  sclk, input  copi, input  ncs);
endinterface

// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 write-only register peripheral: five 8-bit control registers loaded by 16-bit frames
// {R/W, addr[6:0], data[7:0]}, with all SPI pins oversampled and synchronized into the clk domain.
module spi_reg_peripheral (
    input  logic                        clk,
    input  logic                        rst_n,
    spi_reg_peripheral_if.slave         spi,
    output logic [7:0]                  en_reg_out_7_0,
    output logic [7:0]                  en_reg_out_15_8,
    output logic [7:0]                  en_reg_pwm_7_0,
    output logic [7:0]                  en_reg_pwm_15_8,
    output logic [7:0]                  pwm_duty_cycle
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam int          NUM_REGS  = 5;
    localparam logic [4:0]  FRAME_LEN = 5'd16;
    localparam logic [4:0]  CNT_SAT   = 5'd17;

    // Bit 0 is the metastability flop, bit 1 the synchronized value, bit 2 the edge-detect history.
    logic [2:0]  sclkPipe_q;
    logic [2:0]  ncsPipe_q;
    logic [1:0]  copiPipe_q;

    state_t      state_q, state_d;
    logic [4:0]  bitCnt_q, bitCnt_d;
    logic [15:0] shift_q, shift_d;
    logic        fallPend_q, fallPend_d;
    logic        commitEn;
    logic [NUM_REGS-1:0][7:0] regFile_q;

    logic sclkRise;
    logic ncsRise;
    logic ncsFall;
    logic ncsSync;
    logic copiSync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclkPipe_q <= 3'b000;
            copiPipe_q <= 2'b00;
            ncsPipe_q  <= 3'b111;
        end else begin
            sclkPipe_q <= {sclkPipe_q[1:0], spi.sclk};
            copiPipe_q <= {copiPipe_q[0], spi.copi};
            ncsPipe_q  <= {ncsPipe_q[1:0], spi.ncs};
        end
    end

    assign ncsSync  = ncsPipe_q[1];
    assign copiSync = copiPipe_q[1];
    assign sclkRise = sclkPipe_q[1] & ~sclkPipe_q[2];
    assign ncsRise  = ncsPipe_q[1]  & ~ncsPipe_q[2];
    assign ncsFall  = ~ncsPipe_q[1] &  ncsPipe_q[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bitCnt_q   <= '0;
            shift_q    <= '0;
            fallPend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitCnt_q   <= bitCnt_d;
            shift_q    <= shift_d;
            fallPend_q <= fallPend_d;
        end
    end

    // A falling ncs seen during COMMIT is remembered so the next frame starts from IDLE without loss.
    always_comb begin
        state_d    = state_q;
        bitCnt_d   = bitCnt_q;
        shift_d    = shift_q;
        fallPend_d = 1'b0;
        commitEn   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ncsFall || fallPend_q) begin
                    state_d  = SHIFT;
                    bitCnt_d = '0;
                    shift_d  = '0;
                end
            end
            SHIFT: begin
                if (ncsRise) begin
                    state_d = COMMIT;
                end else if (sclkRise && !ncsSync) begin
                    shift_d = {shift_q[14:0], copiSync};
                    if (bitCnt_q != CNT_SAT) begin
                        bitCnt_d = bitCnt_q + 5'd1;
                    end
                end
            end
            COMMIT: begin
                state_d    = IDLE;
                fallPend_d = ncsFall;
                commitEn   = (bitCnt_q == FRAME_LEN) && shift_q[15];
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Addresses outside the map simply match no register, so such frames fall away silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regFile_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commitEn && (shift_q[14:8] == 7'(i))) begin
                    regFile_q[i] <= shift_q[7:0];
                end
            end
        end
    end

    assign en_reg_out_7_0  = regFile_q[0];
    assign en_reg_out_15_8 = regFile_q[1];
    assign en_reg_pwm_7_0  = regFile_q[2];
    assign en_reg_pwm_15_8 = regFile_q[3];
    assign pwm_duty_cycle  = regFile_q[4];

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Self-checking bench for spi_reg_peripheral: directed vector table, hand-written timing/reset
// sequences, and random frames checked against an address-indexed register model.
module tb_spi_reg_peripheral;

    typedef struct {
        string           name;
        logic [15:0]     word;
        int              nBits;
        logic [4:0][7:0] expRegs;
    } vector_t;

    logic clk;
    logic rst_n;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;

    logic [7:0] model [5];
    int nChecks = 0;
    int nFails  = 0;

    spi_reg_peripheral_if spiBus ();

    spi_reg_peripheral dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .spi             (spiBus.slave),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, need finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [4:0][7:0] mkExp(input logic [7:0] r0, input logic [7:0] r1,
                                               input logic [7:0] r2, input logic [7:0] r3,
                                               input logic [7:0] r4);
        return {r4, r3, r2, r1, r0};
    endfunction

    function automatic logic [7:0] dutReg(input int idx);
        case (idx)
            0:       return en_reg_out_7_0;
            1:       return en_reg_out_15_8;
            2:       return en_reg_pwm_7_0;
            3:       return en_reg_pwm_15_8;
            default: return pwm_duty_cycle;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic checkModel(input string name);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("%s reg%0d", name, i), dutReg(i), model[i]);
        end
    endtask

    // Reference: only a full 16-bit write to a mapped address changes anything.
    task automatic refModel(input logic [15:0] word, input int nBits);
        if (nBits == 16 && word[15] && word[14:8] < 7'd5) begin
            model[word[14:8]] = word[7:0];
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
    endtask

    // Shifts nBits MSB-first with sclk phases of 4 clk each; bits beyond 16 are zero.
    task automatic driveBits(input logic [15:0] word, input int nBits);
        for (int i = 0; i < nBits; i++) begin
            spiBus.copi = (i < 16) ? word[15 - i] : 1'b0;
            repeat (4) @(negedge clk);
            spiBus.sclk = 1'b1;
            repeat (4) @(negedge clk);
            spiBus.sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [15:0] word, input int nBits);
        spiBus.ncs = 1'b0;
        repeat (4) @(negedge clk);
        driveBits(word, nBits);
        spiBus.ncs = 1'b1;
        repeat (8) @(negedge clk);
        refModel(word, nBits);
    endtask

    initial begin
        vector_t vecs [10];
        vecs[0] = '{"wr00_F0",  16'h80F0, 16, mkExp(8'hF0, 8'hAB, 8'h00, 8'h00, 8'h00)};
        vecs[1] = '{"wr01_0F",  16'h810F, 16, mkExp(8'hF0, 8'h0F, 8'h00, 8'h00, 8'h00)};
        vecs[2] = '{"wr02_55",  16'h8255, 16, mkExp(8'hF0, 8'h0F, 8'h55, 8'h00, 8'h00)};
        vecs[3] = '{"wr03_AA",  16'h83AA, 16, mkExp(8'hF0, 8'h0F, 8'h55, 8'hAA, 8'h00)};
        vecs[4] = '{"wr04_80",  16'h8480, 16, mkExp(8'hF0, 8'h0F, 8'h55, 8'hAA, 8'h80)};
        vecs[5] = '{"wr04_FF",  16'h84FF, 16, mkExp(8'hF0, 8'h0F, 8'h55, 8'hAA, 8'hFF)};
        vecs[6] = '{"rd04",     16'h0433, 16, mkExp(8'hF0, 8'h0F, 8'h55, 8'hAA, 8'hFF)};
        vecs[7] = '{"wr10_77",  16'h9077, 16, mkExp(8'hF0, 8'h0F, 8'h55, 8'hAA, 8'hFF)};
        vecs[8] = '{"short15",  16'h823C, 15, mkExp(8'hF0, 8'h0F, 8'h55, 8'hAA, 8'hFF)};
        vecs[9] = '{"long17",   16'h823C, 17, mkExp(8'hF0, 8'h0F, 8'h55, 8'hAA, 8'hFF)};

        rst_n       = 1'b0;
        spiBus.sclk = 1'b0;
        spiBus.copi = 1'b0;
        spiBus.ncs  = 1'b1;
        clearModel();
        repeat (3) @(negedge clk);
        checkModel("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Commit must land exactly on the 4th clk rising edge after ncs rises.
        spiBus.ncs = 1'b0;
        repeat (4) @(negedge clk);
        driveBits(16'h81AB, 16);
        spiBus.ncs = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("latency edge%0d", k), en_reg_out_15_8, (k < 4) ? 8'h00 : 8'hAB);
        end
        refModel(16'h81AB, 16);
        repeat (6) @(negedge clk);
        checkModel("after wr01_AB");

        for (int v = 0; v < 10; v++) begin
            applyStimulus(vecs[v].word, vecs[v].nBits);
            for (int i = 0; i < 5; i++) begin
                checkOutput($sformatf("%s reg%0d", vecs[v].name, i), dutReg(i), vecs[v].expRegs[i]);
            end
        end

        for (int n = 0; n < 40; n++) begin
            logic [15:0] word;
            int          pick;
            int          nBits;
            pick = $urandom_range(0, 4);
            nBits = (pick == 0) ? 15 : (pick == 4) ? 17 : 16;
            word[15]   = ($urandom_range(0, 3) != 0);
            word[14:8] = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(5, 127)) : 7'($urandom_range(0, 4));
            word[7:0]  = 8'($urandom);
            applyStimulus(word, nBits);
            checkModel($sformatf("rand%0d", n));
        end

        // Reset in the middle of a write must abort it and clear every register.
        spiBus.ncs = 1'b0;
        repeat (4) @(negedge clk);
        driveBits(16'h80FF, 10);
        rst_n = 1'b0;
        clearModel();
        @(negedge clk);
        checkModel("midframe reset");
        spiBus.ncs  = 1'b1;
        spiBus.sclk = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkModel("after reset release");
        applyStimulus(16'h8012, 16);
        checkOutput("post-reset wr00_12", en_reg_out_7_0, 8'h12);
        checkModel("post-reset");

        // Back-to-back frames with the minimum 3-clk ncs-high gap.
        spiBus.ncs = 1'b0;
        repeat (4) @(negedge clk);
        driveBits(16'h8301, 16);
        spiBus.ncs = 1'b1;
        repeat (3) @(negedge clk);
        spiBus.ncs = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("b2b first", en_reg_pwm_15_8, 8'h01);
        refModel(16'h8301, 16);
        repeat (4) @(negedge clk);
        driveBits(16'h8302, 16);
        spiBus.ncs = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("b2b second", en_reg_pwm_15_8, 8'h02);
        refModel(16'h8302, 16);
        checkModel("b2b final");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/spi_reg_peripheral.md
SPI_REG_PERIPHERAL -- requirements
Module: spi_reg_peripheral

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Ports (clock and reset first):
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sclk  input  1  SPI serial clock from controller, asynchronous to clk
- copi  input  1  SPI controller-out/peripheral-in data, asynchronous
- ncs  input  1  SPI chip select, active low, asynchronous
- en_reg_out_7_0  output  8  register 0x00, output enables for outputs 7..0
- en_reg_out_15_8  output  8  register 0x01, output enables for outputs 15..8
- en_reg_pwm_7_0  output  8  register 0x02, PWM enables for outputs 7..0
- en_reg_pwm_15_8  output  8  register 0x03, PWM enables for outputs 15..8
- pwm_duty_cycle  output  8  register 0x04, shared PWM duty cycle
REQ-003 SHALL have no parameters; register map fixed as in REQ-002.

Function
REQ-004 sclk, copi and ncs SHALL each pass through a 2-flop synchronizer clocked by clk, plus one history flop for edge detection.
REQ-005 Synchronizer reset values: sclk 0, copi 0, ncs 1 (idle).
REQ-006 SPI mode 0: copi SHALL be sampled on the synchronized sclk rising edge; MSB first.
REQ-007 Frame = exactly 16 bits: bit15 R/W (1=write), bits14:8 address (7 bits), bits7:0 data.
REQ-008 FSM states: IDLE, SHIFT, COMMIT.
- IDLE -> SHIFT on synchronized ncs falling edge; bit counter and shift register cleared.
- SHIFT: each synchronized sclk rising edge while synchronized ncs low shifts in one bit and increments the counter.
- SHIFT -> COMMIT on synchronized ncs rising edge.
- COMMIT -> IDLE unconditionally after one clk cycle.
REQ-009 5-bit bit counter SHALL saturate at 17; any count other than exactly 16 in COMMIT discards the frame.
REQ-010 In COMMIT, a frame with count 16, R/W=1 and address 0x00-0x04 SHALL update exactly one register with the data byte; all other registers hold.
REQ-011 R/W=0 frames (reads) SHALL be discarded; no register changes and no output driven.
REQ-012 Addresses 0x05-0x7F SHALL be discarded silently.
REQ-013 Latency: register SHALL change on the 4th rising clk edge after the ncs pin rises, given input setup is met.
REQ-014 An sclk rising edge detected in the same cycle as the ncs rising edge SHALL NOT be shifted in (ncs takes precedence).
REQ-015 sclk edges while in IDLE or COMMIT SHALL be ignored.
REQ-016 Timing requirement: sclk high and low phases each SHALL be at least 3 clk periods; ncs high between frames at least 3 clk periods. Behaviour outside these limits is undefined but SHALL NOT corrupt registers except via a valid 16-bit write frame.
REQ-017 A new ncs falling edge in COMMIT SHALL be handled on the next IDLE cycle; no frame is lost when ncs is high for at least 3 clk periods.

Reset
REQ-018 While rst_n=0, all five register outputs SHALL be 8'h00, FSM in IDLE, counter 0, shift register 0.
REQ-019 Reset asserted mid-frame SHALL abort the frame; registers read 8'h00 and the partial frame is never committed.
REQ-020 If ncs is held low through reset release, the reset value of 1 produces a falling edge 2 cycles later; the resulting frame is committed only if it then counts exactly 16 bits.

Verification
REQ-021 Reset then write 0x80,0x01,0xAB (R/W=1, addr 0x01, data 0xAB) -> en_reg_out_15_8=0xAB on 4th clk edge after ncs rise; other registers remain 0x00.
REQ-022 Write to each of addresses 0x00-0x04 with data 0xF0,0x0F,0x55,0xAA,0x80 -> each register holds its value; a later write of 0xFF to 0x04 changes only pwm_duty_cycle.
REQ-023 Read frame 0x04,0x33 and write frame to address 0x10 (0x90,0x77) -> all registers unchanged.
REQ-024 15-bit frame and 17-bit frame, each a write to 0x02 with data 0x3C -> en_reg_pwm_7_0 unchanged.
REQ-025 Assert rst_n=0 after bit 10 of a write to 0x00 with data 0xFF, release, then send a full write to 0x00 with data 0x12 -> register 0x00 reads 0x00 after reset, then 0x12.
REQ-026 Back-to-back writes to 0x03 with data 0x01 then 0x02, ncs high for 3 clk periods between frames -> en_reg_pwm_15_8 reads 0x01, then 0x02; no frame is dropped.
